line_burst_adapter: RTL and testbench

//  Bridges a cache's single-transfer line port to a narrow burst memory bus.
//  - Read: collects BEATS beats into a full line.
//  - Write: splits a latched line into BEATS beats.
//  - Sits between the L1 cache datapath and the memory/arbiter port.
//  - Generalises fixed-width line/word adaptation to arbitrary line and bus widths.

---
 rtl/line_burst_adapter.sv | 183 ++++++++++++++++++
 tb/tb_line_burst_adapter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module   : line_burst_adapter
// Purpose  : Bridges a cache single-transfer line port to a narrow burst
//            memory bus. Reads gather BEATS beats into one line; writes split
//            a latched line into BEATS beats.
// Ports    : clk, rst           - clock (rising edge), async active-high reset
//            address_i          - line request address
//            read_i / write_i   - level requests, held until resp_o
//            line_i / line_o    - line write data in / assembled read line out
//            resp_o             - one-cycle line-complete pulse
//            address_o          - memory burst start address
//            read_o / write_o   - memory burst active (registered)
//            burst_o / burst_i  - write beat out / read beat in
//            resp_i             - memory beat handshake
// Config   : LINE_ADAPTER_WRAP_EN - critical-word-first ordering; the burst
//            starts at the beat addressed by address_i and wraps around.
// Revision : 1.0 - initial release
// ============================================================================
module line_burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BUS_W-1:0]  burst_o,
  input  logic [BUS_W-1:0]  burst_i,
  input  logic              resp_i
);

  localparam int BEATS  = LINE_W / BUS_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BOFF_W = $clog2(BUS_W / 8);
  localparam int CNT_W  = $clog2(BEATS);
  localparam int BW_LOG = $clog2(BUS_W);
  localparam int LW_LOG = $clog2(LINE_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    start_q, start_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_buf_q, line_buf_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                resp_q, resp_d;

  logic [CNT_W-1:0]    w_start;
  logic [ADDR_W-1:0]   w_addr_aligned;
  logic [CNT_W-1:0]    w_idx;
  logic [LW_LOG-1:0]   w_base;
  logic [LINE_W-1:0]   w_merged;
  logic                w_unused_addr_bits;

`ifdef LINE_ADAPTER_WRAP_EN
  // Critical-word-first: the requested beat goes out first.
  assign w_start            = address_i[OFF_W-1:BOFF_W];
  assign w_addr_aligned     = {address_i[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
  assign w_unused_addr_bits = ^address_i[BOFF_W-1:0];
`else
  assign w_start            = '0;
  assign w_addr_aligned     = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused_addr_bits = ^address_i[OFF_W-1:0];
`endif

  // Slot index wraps naturally because BEATS is a power of two.
  assign w_idx  = start_q + cnt_q;
  assign w_base = {w_idx, {BW_LOG{1'b0}}};

  // Line buffer with the current read beat dropped into its slot.
  always_comb begin
    w_merged                    = line_buf_q;
    w_merged[w_base +: BUS_W]   = burst_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    addr_d     = addr_q;
    line_buf_d = line_buf_q;
    line_d     = line_q;
    resp_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read_i) begin
          state_d = S_RD;
          cnt_d   = '0;
          start_d = w_start;
          addr_d  = w_addr_aligned;
        end else if (write_i) begin
          state_d    = S_WR;
          cnt_d      = '0;
          start_d    = w_start;
          addr_d     = w_addr_aligned;
          line_buf_d = line_i;
        end
      end
      S_RD: begin
        if (resp_i) begin
          line_buf_d = w_merged;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            // Publish only a complete line so an aborted read never leaks.
            line_d  = w_merged;
            state_d = S_DONE;
            resp_d  = 1'b1;
          end
        end
      end
      S_WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
            resp_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    read_d  = (state_d == S_RD);
    write_d = (state_d == S_WR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      start_q    <= '0;
      addr_q     <= '0;
      line_buf_q <= '0;
      line_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      line_buf_q <= line_buf_d;
      line_q     <= line_d;
      read_q     <= read_d;
      write_q    <= write_d;
      resp_q     <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = write_q ? line_buf_q[w_base +: BUS_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_line_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_burst_adapter
// Purpose  : Directed self-checking bench for line_burst_adapter with the
//            default 256-bit line / 64-bit bus configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_burst_adapter;

  localparam int LINE_W = 256;
  localparam int BUS_W  = 64;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic              resp_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  logic [BUS_W-1:0]  burst_o;
  logic [BUS_W-1:0]  burst_i;
  logic              resp_i;

  int tests = 0;
  int fails = 0;

  line_burst_adapter #(
    .LINE_W(LINE_W),
    .BUS_W (BUS_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .line_i   (line_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .burst_o  (burst_o),
    .burst_i  (burst_i),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full read with resp_i held high; beats are presented in bus order.
  task automatic run_read(input string tag, input logic [31:0] addr,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input logic [31:0] exp_addr, input logic [255:0] exp_line);
    logic [63:0] b[4];
    int k;
    int edges;
    bit acc;
    bit seen;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    k = 0; edges = 0; seen = 0;
    address_i = addr;
    read_i    = 1'b1;
    resp_i    = 1'b1;
    burst_i   = b[0];
    while (!seen && edges < 20) begin
      acc = read_o && resp_i;
      tick;
      edges++;
      if (acc && k < 4) begin
        k++;
        burst_i = (k < 4) ? b[k] : 64'h0;
      end
      if (edges == 1) chk({tag, ":addr"}, address_o, exp_addr);
      if (resp_o) seen = 1;
    end
    read_i = 1'b0;
    // Request cycle counts as cycle 1, so resp_o appears after BEATS+1 edges.
    chk({tag, ":latency"}, edges, 5);
    chk({tag, ":beats"}, k, 4);
    chk({tag, ":line"}, line_o, exp_line);
    tick;
    resp_i = 1'b0;
    chk({tag, ":pulse_end"}, {resp_o, read_o}, 2'b00);
  endtask

  logic [63:0]  wexp[4];
  logic [255:0] last_line;
  int           k;
  int           edges;
  int           resp_cnt;
  bit           acc;
  bit           done;
  bit           any_resp;

  initial begin
    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    tick; tick;
    chk("reset_ctl", {read_o, write_o, resp_o}, 3'b000);
    chk("reset_addr", address_o, 32'h0);
    chk("reset_burst", burst_o, 64'h0);
    chk("reset_line", line_o, 256'h0);
    rst = 1'b0;
    tick;

    // Reset in the middle of a read burst.
    address_i = 32'h1000_0040; read_i = 1'b1;
    tick;
    chk("rst_mid:read_started", read_o, 1'b1);
    resp_i = 1'b1; burst_i = 64'h1111_1111_1111_1111;
    tick; tick;
    rst = 1'b1;
    #1;
    chk("rst_mid:read_drop", read_o, 1'b0);
    read_i = 1'b0; resp_i = 1'b0;
    tick;
    rst = 1'b0;
    any_resp = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (resp_o) any_resp = 1;
    end
    chk("rst_mid:no_resp", any_resp, 1'b0);
    chk("rst_mid:idle", {read_o, write_o}, 2'b00);
    chk("rst_mid:line", line_o, 256'h0);

    // Basic read with resp_i held high.
    run_read("rd_basic", 32'h1000_0040,
             64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
             64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3,
             32'h1000_0040,
             {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0});

    // Spurious handshakes while idle must not move the adapter.
    resp_i = 1'b1; tick;
    resp_i = 1'b0; tick;
    resp_i = 1'b1; tick;
    resp_i = 1'b0;
    chk("spurious_idle", {read_o, write_o, resp_o}, 3'b000);
    run_read("rd_after_spurious", 32'h1000_0000,
             64'hC0, 64'hC1, 64'hC2, 64'hC3,
             32'h1000_0000,
             {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    last_line = {64'hC3, 64'hC2, 64'hC1, 64'hC0};

    // Write with resp_i stalling every other cycle.
    wexp[0] = 64'hA; wexp[1] = 64'hB; wexp[2] = 64'hC; wexp[3] = 64'hD;
    address_i = 32'h2000_0000;
    line_i    = {64'hD, 64'hC, 64'hB, 64'hA};
    write_i   = 1'b1;
    resp_i    = 1'b0;
    k = 0; edges = 0; resp_cnt = 0; done = 0;
    while (!done && edges < 40) begin
      if (write_o && k < 4) chk("wr_beat", burst_o, wexp[k]);
      acc = write_o && resp_i;
      tick;
      edges++;
      if (acc) k++;
      if (resp_o) begin
        resp_cnt++;
        chk("wr_resp_after_4", k, 4);
        write_i = 1'b0;
        done = 1;
      end
      resp_i = (edges % 2 == 1);
    end
    resp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (resp_o) resp_cnt++;
    end
    chk("wr_resp_once", resp_cnt, 1);
    chk("wr_line_untouched", line_o, last_line);

    // Simultaneous read and write: read first, then write.
    address_i = 32'h3000_0000;
    line_i    = {64'h44, 64'h33, 64'h22, 64'h11};
    burst_i   = 64'h5555;
    read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
    tick;
    chk("rw:read_first", {read_o, write_o}, 2'b10);
    edges = 0;
    while (!resp_o && edges < 20) begin
      tick;
      edges++;
    end
    chk("rw:read_done", resp_o, 1'b1);
    read_i = 1'b0;
    chk("rw:read_line", line_o, {64'h5555, 64'h5555, 64'h5555, 64'h5555});
    tick;
    chk("rw:gap", write_o, 1'b0);
    tick;
    chk("rw:write_start", {read_o, write_o}, 2'b01);
    chk("rw:write_addr", address_o, 32'h3000_0000);
    chk("rw:write_beat0", burst_o, 64'h11);
    edges = 0;
    while (!resp_o && edges < 20) begin
      tick;
      edges++;
    end
    chk("rw:write_done", resp_o, 1'b1);
    write_i = 1'b0; resp_i = 1'b0;
    tick;

    // Unaligned read: ordering depends on wrap configuration.
`ifdef LINE_ADAPTER_WRAP_EN
    run_read("rd_wrap", 32'h1000_0050,
             64'hE0, 64'hE1, 64'hE2, 64'hE3,
             32'h1000_0050,
             {64'hE1, 64'hE0, 64'hE3, 64'hE2});
`else
    run_read("rd_nowrap", 32'h1000_0050,
             64'hE0, 64'hE1, 64'hE2, 64'hE3,
             32'h1000_0040,
             {64'hE3, 64'hE2, 64'hE1, 64'hE0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
